// File: rtl/expr_pkg.sv
// Shared definitions for the streaming expression evaluator: one-hot grammar
// states, the ASCII characters the grammar recognises, and character helpers.
package expr_pkg;

    typedef enum logic [3:0] {
        S_NUM  = 4'b0001,
        S_OP   = 4'b0010,
        S_ERR  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    // Only meaningful when is_digit(c) holds; yields 0..9.
    function automatic logic [3:0] digit_val(input logic [7:0] c);
        logic [7:0] diff;
        diff = c - CH_0;
        return diff[3:0];
    endfunction

endpackage

// File: rtl/expr_syntax_fsm.sv
// Grammar state machine for digit (op digit)*: tracks whether a digit or an
// operator is expected, and flags which datapath action each accepted character needs.
module expr_syntax_fsm
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       accept,
    input  logic [7:0] ch,
    input  logic       last,
    input  logic       release_out,
    output state_t     state,
    output logic       take_digit,
    output logic       take_plus,
    output logic       take_star,
    output logic       finish,
    output logic       finish_ok
);

    state_t next;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_NUM;
        end else begin
            state <= next;
        end
    end

    // A final character overrides the grammar move and parks the machine in S_DONE.
    always_comb begin
        next       = state;
        take_digit = 1'b0;
        take_plus  = 1'b0;
        take_star  = 1'b0;
        finish     = 1'b0;
        finish_ok  = 1'b0;
        case (state)
            S_NUM: begin
                if (accept) begin
                    if (is_digit(ch)) begin
                        take_digit = 1'b1;
                        next       = S_OP;
                    end else begin
                        next = S_ERR;
                    end
                end
            end
            S_OP: begin
                if (accept) begin
                    if (ch == CH_PLUS) begin
                        take_plus = 1'b1;
                        next      = S_NUM;
                    end else if (ch == CH_STAR) begin
                        take_star = 1'b1;
                        next      = S_NUM;
                    end else begin
                        next = S_ERR;
                    end
                end
            end
            S_ERR: begin
                next = S_ERR;
            end
            S_DONE: begin
                if (release_out) begin
                    next = S_NUM;
                end
            end
            default: begin
                next = S_NUM;
            end
        endcase
        if (accept && last) begin
            finish    = 1'b1;
            finish_ok = take_digit;
            next      = S_DONE;
        end
    end

endmodule

// File: rtl/expr_eval_ctrl.sv
// Streaming expression checker/evaluator: accepts one ASCII character per
// handshake and returns pass/fail plus the value with '*' binding tighter than '+'.
module expr_eval_ctrl
    import expr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_char,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_ok,
    output logic [W-1:0] out_result
);

    state_t       state;
    logic         accept;
    logic         release_out;
    logic         take_digit;
    logic         take_plus;
    logic         take_star;
    logic         finish;
    logic         finish_ok;

    logic [W-1:0] acc;
    logic [W-1:0] prod;
    logic         mul_pend;
    logic [W-1:0] digit;
    logic [W-1:0] prod_next;
    logic [W-1:0] sum_next;

    assign in_ready    = (state != S_DONE);
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid && out_ready;

    expr_syntax_fsm u_fsm (
        .clk         (clk),
        .clr         (clr),
        .accept      (accept),
        .ch          (in_char),
        .last        (in_last),
        .release_out (release_out),
        .state       (state),
        .take_digit  (take_digit),
        .take_plus   (take_plus),
        .take_star   (take_star),
        .finish      (finish),
        .finish_ok   (finish_ok)
    );

    // The final result must include the term being completed by the last digit.
    always_comb begin
        digit     = W'(digit_val(in_char));
        prod_next = mul_pend ? prod * digit : digit;
        sum_next  = acc + prod_next;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            acc      <= '0;
            prod     <= '0;
            mul_pend <= 1'b0;
        end else if (release_out) begin
            acc      <= '0;
            prod     <= '0;
            mul_pend <= 1'b0;
        end else if (accept) begin
            if (take_digit) begin
                prod <= prod_next;
            end
            if (take_plus) begin
                acc      <= acc + prod;
                mul_pend <= 1'b0;
            end
            if (take_star) begin
                mul_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_valid  <= 1'b0;
            out_ok     <= 1'b0;
            out_result <= '0;
        end else if (finish) begin
            out_valid  <= 1'b1;
            out_ok     <= finish_ok;
            out_result <= finish_ok ? sum_next : '0;
        end else if (release_out) begin
            out_valid  <= 1'b0;
            out_ok     <= 1'b0;
            out_result <= '0;
        end
    end

endmodule

// File: doc/expr_eval_ctrl.md
Name: expr_eval_ctrl

Overview:
Streaming controller that accepts an ASCII expression one character per handshake. It checks the grammar digit (op digit)*, where op is '+' or '*' and every operand is a single digit '0'..'9'. In parallel it evaluates the expression with '*' binding tighter than '+', and reports pass/fail plus the value through a result handshake. It sits between a character source (UART/FIFO) and a consumer, and sequences the syntax-check datapath.

Parameters:
W, 8, result/accumulator width; all arithmetic is modulo 2^W.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_char/in_last are valid.
- in_ready  out  1  block can accept a character this cycle.
- in_char  in  8  ASCII character.
- in_last  in  1  in_char is the final character of the expression.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_ok  out  1  expression was syntactically valid; qualified by out_valid.
- out_result  out  W  expression value when out_ok=1, else 0; qualified by out_valid.

Behaviour:
- Transfer rule: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- States, one-hot: S_NUM (expect digit), S_OP (expect op), S_ERR (syntax failed, draining), S_DONE (holding result).
- in_ready = 1 in S_NUM, S_OP and S_ERR; in_ready = 0 in S_DONE.
- Datapath registers:
  - acc (W), sum of completed terms.
  - prod (W), current term.
  - mul_pend (1), previous op was '*'.
- Transitions and actions, applied per input transfer with in_last=0:
  - S_NUM, digit d: prod <= mul_pend ? prod*d : d (truncate to W), then go to S_OP.
  - S_NUM, non-digit: go to S_ERR.
  - S_OP, '+': acc <= acc+prod, mul_pend <= 0, then go to S_NUM.
  - S_OP, '*': mul_pend <= 1, then go to S_NUM.
  - S_OP, any other character: go to S_ERR.
  - S_ERR: discard the character and stay in S_ERR.
- Transfer with in_last=1: process the character as above, then go to S_DONE.
  - out_ok = 1 only if the final character was a legal digit arriving in S_NUM.
  - When ok, out_result = acc + (updated prod), mod 2^W; otherwise out_result = 0.
  - A last character that is an op, or any error earlier in the string, gives out_ok=0.
- Latency: out_valid rises on the cycle after the in_last transfer.
- S_DONE: out_valid=1; out_ok and out_result are held stable until the output transfer.
  - On the output transfer, go to S_NUM and clear acc, prod and mul_pend to 0.
  - in_ready stays 0 in S_DONE, so the next string cannot start in the same cycle as the output transfer.
- Multi-character numbers such as "12" are a syntax error (second digit arrives in S_OP).
- Reset: clr asynchronously forces S_NUM and sets acc=prod=0, mul_pend=0, out_valid=0, out_ok=0, out_result=0. in_ready=1 after reset. clr mid-string or mid-hold drops the partial or pending result with no output.
- in_char and in_last are ignored when no input transfer occurs. out_valid stays low outside S_DONE.

Decomposition:
- Package expr_pkg holds:
  - the one-hot state constants S_NUM, S_OP, S_ERR, S_DONE;
  - ASCII constants CH_0, CH_9, CH_PLUS, CH_STAR;
  - an is_digit helper.
- Sub-module expr_syntax_fsm contains the grammar state machine: S_NUM/S_OP/S_ERR transitions plus the done/ok decision.
- expr_eval_ctrl owns the handshake logic, the acc/prod/mul_pend datapath and the output registers.

Test Plan:
1. "1+2*3" (W=8, out_ready=1): 5 transfers, last on '3' -> one cycle later out_valid=1, out_ok=1, out_result=7. Then in_ready=1 again.
2. "2*3*4+5" -> out_ok=1, out_result=29. Then "9*9*9*9" -> out_result=161, because 6561 mod 256 = 161.
3. Syntax errors, each giving out_ok=0 and out_result=0:
   - "1++2": S_ERR entered at the second '+', remaining characters accepted and discarded.
   - "+".
   - "5+", ending on an op.
   - "12".
4. Backpressure: after "3*3", hold out_ready=0 for 3 cycles -> out_valid=1 and out_result=9 stable throughout, in_ready=0, a pending in_valid is not consumed. Raise out_ready -> output transfer, and the next string starts with acc/prod cleared.
5. Reset mid-string: send "4+", assert clr for 1 cycle, then send "6" with in_last -> out_ok=1, out_result=6, with no residue from the aborted string.
6. Input gaps: "7*8" with in_valid low for random cycles between characters -> out_result=56, out_ok=1, identical to the gap-free run.
